// File: rtl/sdc_req_arbiter_if.sv
// Requester and SD-controller handshake bundle for the two-port SD block arbiter.
// The slave view belongs to the arbiter; the master view is the surrounding requesters/controller.
interface sdc_req_arbiter_if #(
  parameter int BLK_W = 32
);
  logic [1:0]         m_req;
  logic [1:0]         m_wr;
  logic [2*BLK_W-1:0] m_blk;
  logic [1:0]         m_ack;
  logic [63:0]        m_wdata;
  logic [1:0]         m_wdata_req;
  logic [31:0]        m_rdata;
  logic [1:0]         m_rdata_vld;
  logic [1:0]         m_done;
  logic [1:0]         m_err;
  logic               s_req;
  logic               s_wr;
  logic [BLK_W-1:0]   s_blk;
  logic               s_ack;
  logic [31:0]        s_wdata;
  logic               s_wdata_req;
  logic [31:0]        s_rdata;
  logic               s_rdata_vld;
  logic               s_done;
  logic               s_err;
  logic               s_abort;

  modport slave (
    input  m_req, m_wr, m_blk, m_wdata, s_ack, s_wdata_req, s_rdata, s_rdata_vld, s_done, s_err,
    output m_ack, m_wdata_req, m_rdata, m_rdata_vld, m_done, m_err, s_req, s_wr, s_blk, s_wdata, s_abort
  );

  modport master (
    output m_req, m_wr, m_blk, m_wdata, s_ack, s_wdata_req, s_rdata, s_rdata_vld, s_done, s_err,
    input  m_ack, m_wdata_req, m_rdata, m_rdata_vld, m_done, m_err, s_req, s_wr, s_blk, s_wdata, s_abort
  );
endinterface

// File: rtl/sdc_req_arbiter.sv
// Round-robin arbiter sharing one SD block controller between two requesters,
// with per-transaction watchdog abort and per-requester completed-block counters.
module sdc_req_arbiter #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50000000,
  parameter int          BLK_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  sdc_req_arbiter_if.slave bus,
  output logic [1:0]      grant,
  output logic [63:0]     xfer_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t           state, state_nxt;
  logic             owner, last_grant, win;
  logic [1:0]       sel;
  logic             wr_q;
  logic [BLK_W-1:0] blk_q;
  logic [31:0]      wd;
  logic             active, act, done_hit, expire;

  assign sel      = owner ? 2'b10 : 2'b01;
  assign active   = (state == ISSUE) || (state == XFER);
  assign act      = bus.s_ack | bus.s_wdata_req | bus.s_rdata_vld | bus.s_done;
  assign done_hit = active && bus.s_done;
  // Activity includes s_done, so a completion in the expiry cycle always beats the abort.
  assign expire   = active && !act && (TIMEOUT_CYC != 32'd0) && (wd == TIMEOUT_CYC - 32'd1);
  assign win      = (&bus.m_req) ? ~last_grant : bus.m_req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|bus.m_req) state_nxt = ISSUE;
      ISSUE: if (done_hit || expire) state_nxt = DONE;
             else if (bus.s_ack)     state_nxt = XFER;
      XFER:  if (done_hit || expire) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_req       = 1'b0;
    bus.s_wr        = 1'b0;
    bus.s_blk       = '0;
    bus.s_wdata     = '0;
    bus.m_wdata_req = 2'b00;
    bus.m_rdata     = '0;
    bus.m_rdata_vld = 2'b00;
    if (state == ISSUE) begin
      bus.s_req = 1'b1;
      bus.s_wr  = wr_q;
      bus.s_blk = blk_q;
    end
    if (state == XFER) begin
      bus.s_wdata     = owner ? bus.m_wdata[63:32] : bus.m_wdata[31:0];
      bus.m_wdata_req = {2{bus.s_wdata_req}} & sel;
      bus.m_rdata     = bus.s_rdata;
      bus.m_rdata_vld = {2{bus.s_rdata_vld}} & sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      grant       <= 2'b00;
      wr_q        <= 1'b0;
      blk_q       <= '0;
      wd          <= '0;
      xfer_cnt    <= '0;
      bus.m_ack   <= 2'b00;
      bus.m_done  <= 2'b00;
      bus.m_err   <= 2'b00;
      bus.s_abort <= 1'b0;
    end else begin
      bus.m_ack   <= 2'b00;
      bus.m_done  <= 2'b00;
      bus.m_err   <= 2'b00;
      bus.s_abort <= 1'b0;
      if (state == IDLE && |bus.m_req) begin
        owner <= win;
        grant <= win ? 2'b10 : 2'b01;
        wr_q  <= bus.m_wr[win];
        blk_q <= win ? bus.m_blk[2*BLK_W-1:BLK_W] : bus.m_blk[BLK_W-1:0];
        wd    <= '0;
      end
      if (active) wd <= act ? 32'd0 : wd + 32'd1;
      if (done_hit) begin
        bus.m_done <= sel;
        bus.m_err  <= bus.s_err ? sel : 2'b00;
        last_grant <= owner;
        grant      <= 2'b00;
        for (int i = 0; i < 2; i++)
          if (sel[i] && !bus.s_err) xfer_cnt[i*32 +: 32] <= xfer_cnt[i*32 +: 32] + 32'd1;
      end else if (expire) begin
        bus.m_done  <= sel;
        bus.m_err   <= sel;
        bus.s_abort <= 1'b1;
        last_grant  <= owner;
        grant       <= 2'b00;
      end else if (state == ISSUE && bus.s_ack) begin
        bus.m_ack <= sel;
      end
    end
  end
endmodule

// File: tb/tb_sdc_req_arbiter.sv
module tb_sdc_req_arbiter;
  localparam int BLK_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  grant;
  logic [63:0] xfer_cnt;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  sdc_req_arbiter_if #(.BLK_W(BLK_W)) bus ();

  sdc_req_arbiter #(.TIMEOUT_CYC(32'd100), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant(grant), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [1:0] oh(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic wait_sreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.s_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic serve(input int id, input bit wr, input logic [31:0] blk, input int nwords,
                       input bit err, input logic [1:0] drop, input logic [31:0] base);
    bit          ok;
    logic [31:0] w, e;
    logic [1:0]  exp_err;
    wait_sreq(ok);
    n_total++; if (ok === 1'b1) n_pass++; else $error("FAIL s_req_seen: observed %0h expected 1", ok);
    n_total++; if (grant === oh(id)) n_pass++; else $error("FAIL grant_owner: observed %0h expected %0h", grant, oh(id));
    n_total++; if (bus.s_blk === blk) n_pass++; else $error("FAIL s_blk: observed %0h expected %0h", bus.s_blk, blk);
    n_total++; if (bus.s_wr === wr) n_pass++; else $error("FAIL s_wr: observed %0h expected %0h", bus.s_wr, wr);
    repeat (3) @(negedge clk);
    bus.s_ack = 1'b1;
    @(negedge clk);
    bus.s_ack = 1'b0;
    #1;
    n_total++; if (bus.m_ack === oh(id)) n_pass++; else $error("FAIL m_ack: observed %0h expected %0h", bus.m_ack, oh(id));
    n_total++; if (bus.s_req === 1'b0) n_pass++; else $error("FAIL s_req_drop: observed %0h expected 0", bus.s_req);
    bus.m_req = bus.m_req & ~drop;
    for (int k = 0; k < nwords; k++) begin
      @(negedge clk);
      w = base + k;
      if (wr) begin
        if (id == 1) bus.m_wdata[63:32] = w; else bus.m_wdata[31:0] = w;
        bus.s_wdata_req = 1'b1;
      end else begin
        bus.s_rdata     = w;
        bus.s_rdata_vld = 1'b1;
      end
      exp_q.push_back(w);
      #1;
      if (k == 0) begin
        n_total++; if (bus.m_ack === 2'b00) n_pass++; else $error("FAIL m_ack_one_cycle: observed %0h expected 0", bus.m_ack);
      end
      if (wr) begin
        n_total++; if (bus.m_wdata_req === oh(id)) n_pass++; else $error("FAIL m_wdata_req: observed %0h expected %0h", bus.m_wdata_req, oh(id));
        if (bus.m_wdata_req[id] && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_total++; if (bus.s_wdata === e) n_pass++; else $error("FAIL s_wdata: observed %0h expected %0h", bus.s_wdata, e);
        end
      end else begin
        n_total++; if (bus.m_rdata_vld === oh(id)) n_pass++; else $error("FAIL m_rdata_vld: observed %0h expected %0h", bus.m_rdata_vld, oh(id));
        if (bus.m_rdata_vld[id] && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_total++; if (bus.m_rdata === e) n_pass++; else $error("FAIL m_rdata: observed %0h expected %0h", bus.m_rdata, e);
        end
      end
    end
    @(negedge clk);
    bus.s_wdata_req = 1'b0;
    bus.s_rdata_vld = 1'b0;
    bus.s_done      = 1'b1;
    bus.s_err       = err;
    @(negedge clk);
    bus.s_done = 1'b0;
    bus.s_err  = 1'b0;
    #1;
    exp_err = err ? oh(id) : 2'b00;
    n_total++; if (bus.m_done === oh(id)) n_pass++; else $error("FAIL m_done: observed %0h expected %0h", bus.m_done, oh(id));
    n_total++; if (bus.m_err === exp_err) n_pass++; else $error("FAIL m_err: observed %0h expected %0h", bus.m_err, exp_err);
    n_total++; if (grant === 2'b00) n_pass++; else $error("FAIL grant_release: observed %0h expected 0", grant);
    n_total++; if (exp_q.size() === 0) n_pass++; else $error("FAIL scoreboard_empty: observed %0d expected 0", exp_q.size());
  endtask

  initial begin
    bit ok;
    int aborts;
    bus.m_req = 2'b00; bus.m_wr = 2'b00; bus.m_blk = '0; bus.m_wdata = '0;
    bus.s_ack = 1'b0; bus.s_wdata_req = 1'b0; bus.s_rdata = '0; bus.s_rdata_vld = 1'b0;
    bus.s_done = 1'b0; bus.s_err = 1'b0;

    @(negedge clk); #1;
    n_total++; if (grant === 2'b00) n_pass++; else $error("FAIL rst_grant: observed %0h expected 0", grant);
    n_total++; if (xfer_cnt === 64'd0) n_pass++; else $error("FAIL rst_xfer_cnt: observed %0h expected 0", xfer_cnt);
    n_total++; if (bus.s_req === 1'b0) n_pass++; else $error("FAIL rst_s_req: observed %0h expected 0", bus.s_req);
    n_total++; if (bus.s_abort === 1'b0) n_pass++; else $error("FAIL rst_s_abort: observed %0h expected 0", bus.s_abort);
    n_total++; if (bus.m_done === 2'b00) n_pass++; else $error("FAIL rst_m_done: observed %0h expected 0", bus.m_done);
    @(negedge clk);
    rst_n = 1'b1;

    bus.m_req = 2'b01; bus.m_blk[31:0] = 32'h10;
    serve(0, 1'b0, 32'h10, 128, 1'b0, 2'b01, 32'd0);
    n_total++; if (xfer_cnt[31:0] === 32'd1) n_pass++; else $error("FAIL cnt0_after_read: observed %0h expected 1", xfer_cnt[31:0]);
    n_total++; if (xfer_cnt[63:32] === 32'd0) n_pass++; else $error("FAIL cnt1_after_read: observed %0h expected 0", xfer_cnt[63:32]);

    bus.m_req = 2'b01; bus.m_blk[31:0] = 32'h44;
    wait_sreq(ok);
    repeat (3) @(negedge clk);
    bus.s_ack = 1'b1;
    @(negedge clk);
    bus.s_ack = 1'b0;
    @(negedge clk);
    bus.s_rdata = 32'hDEAD_BEEF; bus.s_rdata_vld = 1'b1;
    #1;
    n_total++; if (bus.m_rdata_vld === 2'b01) n_pass++; else $error("FAIL xfer_vld_before_rst: observed %0h expected 1", bus.m_rdata_vld);
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (grant === 2'b00) n_pass++; else $error("FAIL arst_grant: observed %0h expected 0", grant);
    n_total++; if (xfer_cnt === 64'd0) n_pass++; else $error("FAIL arst_xfer_cnt: observed %0h expected 0", xfer_cnt);
    n_total++; if (bus.m_rdata_vld === 2'b00) n_pass++; else $error("FAIL arst_rdata_vld: observed %0h expected 0", bus.m_rdata_vld);
    n_total++; if (bus.m_rdata === 32'd0) n_pass++; else $error("FAIL arst_rdata: observed %0h expected 0", bus.m_rdata);
    n_total++; if (bus.s_req === 1'b0) n_pass++; else $error("FAIL arst_s_req: observed %0h expected 0", bus.s_req);
    n_total++; if (bus.s_abort === 1'b0) n_pass++; else $error("FAIL arst_s_abort: observed %0h expected 0", bus.s_abort);
    bus.m_req = 2'b00; bus.s_rdata_vld = 1'b0; bus.s_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    bus.m_req = 2'b11; bus.m_blk = {32'h11, 32'h10};
    serve(0, 1'b0, 32'h10, 4, 1'b0, 2'b01, 32'h0);
    serve(1, 1'b0, 32'h11, 4, 1'b0, 2'b10, 32'h50);
    n_total++; if (xfer_cnt[31:0] === 32'd1) n_pass++; else $error("FAIL cnt0_after_tie: observed %0h expected 1", xfer_cnt[31:0]);
    n_total++; if (xfer_cnt[63:32] === 32'd1) n_pass++; else $error("FAIL cnt1_after_tie: observed %0h expected 1", xfer_cnt[63:32]);

    bus.m_req = 2'b11; bus.m_blk = {32'h1001, 32'h0001};
    for (int i = 0; i < 6; i++)
      serve(i % 2, 1'b0, (i % 2 == 1) ? 32'h1001 : 32'h0001, 4, 1'b0,
            (i == 5) ? 2'b11 : 2'b00, 32'h100 * i);
    n_total++; if (xfer_cnt[31:0] === 32'd4) n_pass++; else $error("FAIL cnt0_after_rr: observed %0h expected 4", xfer_cnt[31:0]);
    n_total++; if (xfer_cnt[63:32] === 32'd4) n_pass++; else $error("FAIL cnt1_after_rr: observed %0h expected 4", xfer_cnt[63:32]);

    bus.m_req = 2'b10; bus.m_wr = 2'b10; bus.m_blk[63:32] = 32'h200;
    serve(1, 1'b1, 32'h200, 8, 1'b1, 2'b10, 32'hA5A5_0000);
    bus.m_wr = 2'b00;
    n_total++; if (xfer_cnt[63:32] === 32'd4) n_pass++; else $error("FAIL cnt1_after_err: observed %0h expected 4", xfer_cnt[63:32]);

    bus.m_req = 2'b01; bus.m_blk[31:0] = 32'h33;
    wait_sreq(ok);
    n_total++; if (ok === 1'b1) n_pass++; else $error("FAIL wd_s_req_seen: observed %0h expected 1", ok);
    aborts = 0;
    for (int k = 0; k < 99; k++) begin
      @(negedge clk); #1;
      if (bus.s_abort) aborts++;
    end
    n_total++; if (aborts === 0) n_pass++; else $error("FAIL wd_no_early_abort: observed %0d expected 0", aborts);
    @(negedge clk); #1;
    n_total++; if (bus.s_abort === 1'b1) n_pass++; else $error("FAIL wd_abort: observed %0h expected 1", bus.s_abort);
    n_total++; if (bus.m_done === 2'b01) n_pass++; else $error("FAIL wd_m_done: observed %0h expected 1", bus.m_done);
    n_total++; if (bus.m_err === 2'b01) n_pass++; else $error("FAIL wd_m_err: observed %0h expected 1", bus.m_err);
    n_total++; if (grant === 2'b00) n_pass++; else $error("FAIL wd_grant: observed %0h expected 0", grant);
    bus.m_req = 2'b00;
    @(negedge clk); #1;
    n_total++; if (bus.s_abort === 1'b0) n_pass++; else $error("FAIL wd_abort_pulse: observed %0h expected 0", bus.s_abort);

    bus.m_req = 2'b01;
    wait_sreq(ok);
    aborts = 0;
    for (int k = 0; k < 99; k++) begin
      @(negedge clk); #1;
      if (bus.s_abort) aborts++;
    end
    bus.s_done = 1'b1; bus.s_err = 1'b0; bus.m_req = 2'b00;
    @(negedge clk);
    bus.s_done = 1'b0;
    #1;
    n_total++; if (aborts === 0) n_pass++; else $error("FAIL race_no_early_abort: observed %0d expected 0", aborts);
    n_total++; if (bus.s_abort === 1'b0) n_pass++; else $error("FAIL race_abort: observed %0h expected 0", bus.s_abort);
    n_total++; if (bus.m_done === 2'b01) n_pass++; else $error("FAIL race_m_done: observed %0h expected 1", bus.m_done);
    n_total++; if (bus.m_err === 2'b00) n_pass++; else $error("FAIL race_m_err: observed %0h expected 0", bus.m_err);
    n_total++; if (xfer_cnt[31:0] === 32'd5) n_pass++; else $error("FAIL race_cnt0: observed %0h expected 5", xfer_cnt[31:0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
